i2c_seq_ctrl: RTL and testbench

Parametrised I2C transaction sequencer that drives one `i2c_driver` master.
After reset it runs an init register-write table, then performs periodic burst reads of a sensor data block (e.g. MPU-6050 0x3B..0x48).
It uses a single system clock with a divided clock-enable tick (no derived clocks) and adds retry on NACK and a read-data valid strobe.
It sits between the sensor-fusion logic and `i2c_driver`.

---
 rtl/i2c_seq_pkg.sv | 28 ++
 rtl/i2c_tick_gen.sv | 33 +++
 rtl/i2c_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_i2c_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_pkg
// Description : Shared types and MPU-6050 register constants for the I2C
//               transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INIT_ISSUE = 3'd1,
        ST_INIT_WAIT  = 3'd2,
        ST_RD_ISSUE   = 3'd3,
        ST_RD_WAIT    = 3'd4,
        ST_POLL_WAIT  = 3'd5,
        ST_FAULT      = 3'd6
    } seq_state_t;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6b;
    localparam logic [7:0] ACCEL_CONFIG = 8'h1c;
    localparam logic [7:0] GYRO_CONFIG  = 8'h1b;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3b;

    localparam int unsigned TIMEOUT_TICKS = 4096;

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Free-running divider; o_tick is high for one clk out of
//               every CLK_DIV clocks (CLK_DIV >= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tick_gen #(
    parameter int CLK_DIV = 6
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int c_CW = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_ctrl
// Description : Init-table writer plus periodic burst reader driving one
//               i2c_driver. Optional WAIT watchdog: I2C_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_seq_ctrl
    import i2c_seq_pkg::*;
#(
    parameter int                CLK_DIV    = 6,
    parameter int                N_INIT     = 3,
    // entry 0 sits in the LSB byte, so PWR_MGMT_1 is written first
    parameter logic [N_INIT*8-1:0] INIT_ADDR = {GYRO_CONFIG, ACCEL_CONFIG, PWR_MGMT_1},
    parameter logic [N_INIT*8-1:0] INIT_DATA = {8'h00, 8'h00, 8'h00},
    parameter logic [7:0]        RD_ADDR    = ACCEL_XOUT_H,
    parameter int                RD_LEN     = 6,
    parameter int                POLL_TICKS = 1000,
    parameter int                MAX_RETRY  = 3,
    parameter logic [6:0]        SLAVE_ADDR = 7'h68
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  drv_tick,
    output logic                  drv_run_req,
    output logic                  drv_r_en,
    output logic [6:0]            drv_slave_addr,
    output logic [7:0]            drv_reg_addr,
    output logic [7:0]            drv_send_data,
    output logic [3:0]            drv_num_data,
    input  logic                  drv_end_flag,
    input  logic                  drv_nack,
    input  logic [63:0]           drv_rx_data,
    output logic [8*RD_LEN-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  init_done,
    output logic                  fault,
    output logic                  busy
);
    localparam int c_RW = $clog2(MAX_RETRY + 1) + 1;
    localparam int c_PW = $clog2(POLL_TICKS) + 1;
    localparam logic [2:0]      c_LAST_IDX  = 3'(N_INIT - 1);
    localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);
    localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_TICKS - 1);

    logic w_tick;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // Init table unpacked to a power-of-two array so a 3-bit index is exact
    logic [7:0] w_init_addr [8];
    logic [7:0] w_init_data [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_init_tab
        if (gi < N_INIT) begin : g_used
            assign w_init_addr[gi] = INIT_ADDR[gi*8 +: 8];
            assign w_init_data[gi] = INIT_DATA[gi*8 +: 8];
        end else begin : g_pad
            assign w_init_addr[gi] = 8'h00;
            assign w_init_data[gi] = 8'h00;
        end
    end

    if (RD_LEN < 8) begin : g_rx_unused
        logic w_unused;
        assign w_unused = ^drv_rx_data[63:8*RD_LEN];
    end

    seq_state_t          r_state, w_state_nxt;
    logic [2:0]          r_idx, w_idx_nxt;
    logic [c_RW-1:0]     r_retry, w_retry_nxt;
    logic [c_PW-1:0]     r_poll, w_poll_nxt;
    logic                r_run_req, w_run_req_nxt;
    logic                r_r_en, w_r_en_nxt;
    logic [7:0]          r_reg_addr, w_reg_addr_nxt;
    logic [7:0]          r_send_data, w_send_data_nxt;
    logic [3:0]          r_num_data, w_num_data_nxt;
    logic [8*RD_LEN-1:0] r_rd_data, w_rd_data_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;
    logic                r_init_done, w_init_done_nxt;
    logic                r_fault, w_fault_nxt;
    logic                w_end, w_nack, w_in_wait;

    assign w_in_wait = (r_state == ST_INIT_WAIT) || (r_state == ST_RD_WAIT);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [11:0] r_wdog;
    logic        w_timeout;

    assign w_timeout = (r_wdog == 12'(TIMEOUT_TICKS - 1));
    assign w_end     = drv_end_flag | w_timeout;
    // a real completion on the expiry tick wins over the timeout
    assign w_nack    = drv_end_flag ? drv_nack : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (!w_in_wait) begin
            r_wdog <= '0;
        end else if (w_tick) begin
            r_wdog <= w_end ? 12'd0 : r_wdog + 12'd1;
        end
    end
`else
    assign w_end  = drv_end_flag;
    assign w_nack = drv_nack;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_retry     <= '0;
            r_poll      <= '0;
            r_run_req   <= 1'b0;
            r_r_en      <= 1'b0;
            r_reg_addr  <= '0;
            r_send_data <= '0;
            r_num_data  <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_init_done <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_retry     <= w_retry_nxt;
            r_poll      <= w_poll_nxt;
            r_run_req   <= w_run_req_nxt;
            r_r_en      <= w_r_en_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_send_data <= w_send_data_nxt;
            r_num_data  <= w_num_data_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_init_done <= w_init_done_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_retry_nxt     = r_retry;
        w_poll_nxt      = r_poll;
        w_run_req_nxt   = r_run_req;
        w_r_en_nxt      = r_r_en;
        w_reg_addr_nxt  = r_reg_addr;
        w_send_data_nxt = r_send_data;
        w_num_data_nxt  = r_num_data;
        w_rd_data_nxt   = r_rd_data;
        w_rd_valid_nxt  = 1'b0;
        w_init_done_nxt = r_init_done;
        w_fault_nxt     = r_fault;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = r_init_done ? ST_RD_ISSUE : ST_INIT_ISSUE;
                end
            end
            ST_INIT_ISSUE: begin
                if (w_tick) begin
                    w_r_en_nxt      = 1'b0;
                    w_reg_addr_nxt  = w_init_addr[r_idx];
                    w_send_data_nxt = w_init_data[r_idx];
                    w_num_data_nxt  = 4'd1;
                    w_run_req_nxt   = 1'b1;
                    w_state_nxt     = ST_INIT_WAIT;
                end
            end
            ST_RD_ISSUE: begin
                if (w_tick) begin
                    w_r_en_nxt     = 1'b1;
                    w_reg_addr_nxt = RD_ADDR;
                    w_num_data_nxt = 4'(RD_LEN);
                    w_run_req_nxt  = 1'b1;
                    w_state_nxt    = ST_RD_WAIT;
                end
            end
            ST_INIT_WAIT, ST_RD_WAIT: begin
                if (w_tick && w_end) begin
                    w_run_req_nxt = 1'b0;
                    if (w_nack) begin
                        if (r_retry == c_MAX_RETRY) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_retry_nxt = r_retry + 1'b1;
                            if (!enable) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = (r_state == ST_RD_WAIT) ? ST_RD_ISSUE
                                                                      : ST_INIT_ISSUE;
                            end
                        end
                    end else begin
                        w_retry_nxt = '0;
                        w_poll_nxt  = '0;
                        if (r_state == ST_RD_WAIT) begin
                            w_rd_data_nxt  = drv_rx_data[8*RD_LEN-1:0];
                            w_rd_valid_nxt = 1'b1;
                            w_state_nxt    = enable ? ST_POLL_WAIT : ST_IDLE;
                        end else if (r_idx == c_LAST_IDX) begin
                            w_init_done_nxt = 1'b1;
                            w_idx_nxt       = '0;
                            w_state_nxt     = enable ? ST_POLL_WAIT : ST_IDLE;
                        end else begin
                            w_idx_nxt   = r_idx + 3'd1;
                            w_state_nxt = enable ? ST_INIT_ISSUE : ST_IDLE;
                        end
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_poll == c_POLL_LAST) begin
                        w_state_nxt = ST_RD_ISSUE;
                    end else begin
                        w_poll_nxt = r_poll + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                w_run_req_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign drv_tick       = w_tick;
    assign drv_run_req    = r_run_req;
    assign drv_r_en       = r_r_en;
    assign drv_slave_addr = SLAVE_ADDR;
    assign drv_reg_addr   = r_reg_addr;
    assign drv_send_data  = r_send_data;
    assign drv_num_data   = r_num_data;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign init_done      = r_init_done;
    assign fault          = r_fault;
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_POLL_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_i2c_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_seq_ctrl
// Description : Directed/randomized bench for i2c_seq_ctrl with an inline
//               driver responder and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_seq_ctrl;
    localparam int c_CLK_DIV    = 3;
    localparam int c_POLL_TICKS = 8;
    localparam int c_RD_LEN     = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        drv_tick, drv_run_req, drv_r_en;
    logic [6:0]  drv_slave_addr;
    logic [7:0]  drv_reg_addr, drv_send_data;
    logic [3:0]  drv_num_data;
    logic        drv_end_flag = 1'b0;
    logic        drv_nack = 1'b0;
    logic [63:0] drv_rx_data = '0;
    logic [8*c_RD_LEN-1:0] rd_data;
    logic        rd_valid, init_done, fault, busy;

    int checks = 0;
    int errors = 0;

    // reference: init table order and the expected last good burst
    logic [7:0] exp_init_addr [3] = '{8'h6b, 8'h1c, 8'h1b};
    logic [7:0] exp_init_data [3] = '{8'h00, 8'h00, 8'h00};
    logic [47:0] model_rd = '0;

    always #5 clk = ~clk;

    i2c_seq_ctrl #(
        .CLK_DIV    (c_CLK_DIV),
        .POLL_TICKS (c_POLL_TICKS),
        .RD_LEN     (c_RD_LEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .drv_tick       (drv_tick),
        .drv_run_req    (drv_run_req),
        .drv_r_en       (drv_r_en),
        .drv_slave_addr (drv_slave_addr),
        .drv_reg_addr   (drv_reg_addr),
        .drv_send_data  (drv_send_data),
        .drv_num_data   (drv_num_data),
        .drv_end_flag   (drv_end_flag),
        .drv_nack       (drv_nack),
        .drv_rx_data    (drv_rx_data),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .init_done      (init_done),
        .fault          (fault),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // leaves time at 1ns after the next drv_tick edge
    task automatic wait_tick_edge();
        do @(negedge clk); while (drv_tick !== 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (drv_run_req === 1'b1) return;
        end
        check({tag, "_req_seen"}, drv_run_req, 1'b1);
    endtask

    // Waits for a request, checks it, holds it `delay` ticks, then completes it
    task automatic serve(input string tag, input logic r_en, input logic [7:0] reg_a,
                         input logic [7:0] wdata, input logic [3:0] num,
                         input bit nack, input logic [63:0] rx, input int delay);
        wait_req(tag);
        check({tag, "_r_en"}, drv_r_en, r_en);
        check({tag, "_reg"}, drv_reg_addr, reg_a);
        check({tag, "_num"}, drv_num_data, num);
        if (!r_en) check({tag, "_wdata"}, drv_send_data, wdata);
        for (int d = 0; d < delay; d++) begin
            wait_tick_edge();
            check({tag, "_held"}, drv_run_req, 1'b1);
        end
        do @(negedge clk); while (drv_tick !== 1'b1);
        drv_end_flag = 1'b1;
        drv_nack     = nack;
        drv_rx_data  = rx;
        @(posedge clk);
        #1;
        drv_end_flag = 1'b0;
        drv_nack     = 1'b0;
        check({tag, "_drop"}, drv_run_req, 1'b0);
    endtask

    // counts ticks from a completion until the read-issue state is entered
    task automatic measure_poll(input string tag);
        int n = 0;
        while (n < 100) begin
            wait_tick_edge();
            n++;
            if (busy === 1'b1) break;
        end
        check({tag, "_poll_ticks"}, 64'(n), 64'(c_POLL_TICKS));
        check({tag, "_gap"}, drv_run_req, 1'b0);
    endtask

    task automatic check_read_ok(input string tag, input logic [63:0] rx);
        model_rd = rx[47:0];
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"}, rd_data, model_rd);
        @(posedge clk);
        #1;
        check({tag, "_valid_once"}, rd_valid, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [63:0] rx;
        int nn, lows;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {drv_tick, drv_run_req, drv_r_en, drv_reg_addr, drv_send_data,
                             drv_num_data, rd_valid, init_done, fault, busy}, 27'd0);
        check("reset_rd_data", rd_data, 48'd0);
        check("slave_addr", drv_slave_addr, 7'h68);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // init table; entry 1 NACKed twice before its ack
        serve("init0", 1'b0, exp_init_addr[0], exp_init_data[0], 4'd1, 1'b0, '0, 0);
        serve("init1_a", 1'b0, exp_init_addr[1], exp_init_data[1], 4'd1, 1'b1, '0, 1);
        serve("init1_b", 1'b0, exp_init_addr[1], exp_init_data[1], 4'd1, 1'b1, '0, 0);
        serve("init1_c", 1'b0, exp_init_addr[1], exp_init_data[1], 4'd1, 1'b0, '0, 2);
        check("init_not_done", init_done, 1'b0);
        serve("init2", 1'b0, exp_init_addr[2], exp_init_data[2], 4'd1, 1'b0, '0, 0);
        check("init_done", init_done, 1'b1);
        check("no_fault", fault, 1'b0);
        measure_poll("first");

        // directed first read: upper two bytes must be discarded
        rx = 64'h0807060504030201;
        serve("rd0", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b0, rx, 1);
        check_read_ok("rd0", rx);
        check("rd0_exact", rd_data, 48'h060504030201);
        measure_poll("rd0");

        // randomized reads with random NACK counts and response delays
        for (int k = 0; k < 5; k++) begin
            nn = $urandom_range(0, 2);
            for (int j = 0; j < nn; j++) begin
                serve("rnd_nack", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b1,
                      {$urandom, $urandom}, $urandom_range(0, 3));
                check("rnd_nack_valid", rd_valid, 1'b0);
                check("rnd_nack_keep", rd_data, model_rd);
            end
            rx = {$urandom, $urandom};
            serve("rnd_ack", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b0, rx, $urandom_range(0, 3));
            check_read_ok("rnd", rx);
            measure_poll("rnd");
        end
        check("rnd_no_fault", fault, 1'b0);

        // withheld completion
        wait_req("wd");
`ifdef I2C_SEQ_TIMEOUT_EN
        nn = 0;
        while (nn < 5000) begin
            wait_tick_edge();
            nn++;
            if (drv_run_req !== 1'b1) break;
        end
        check("wd_drop_ticks", 64'(nn), 64'd4096);
        wait_tick_edge();
        check("wd_reissue", drv_run_req, 1'b1);
`else
        lows = 0;
        for (int t = 0; t < 4200; t++) begin
            wait_tick_edge();
            if (drv_run_req !== 1'b1) lows++;
        end
        check("wd_held_high", 64'(lows), 64'd0);
`endif
        rx = {$urandom, $urandom};
        serve("wd_ack", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b0, rx, 0);
        check_read_ok("wd", rx);
        measure_poll("wd");

        // enable dropped before the request: transaction completes, then idle
        enable = 1'b0;
        rx = {$urandom, $urandom};
        serve("en_low", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b0, rx, 2);
        check_read_ok("en_low", rx);
        check("en_low_idle", busy, 1'b0);
        lows = 0;
        for (int t = 0; t < 40; t++) begin
            wait_tick_edge();
            if (drv_run_req !== 1'b0 || busy !== 1'b0) lows++;
        end
        check("en_low_quiet", 64'(lows), 64'd0);
        enable = 1'b1;
        rx = {$urandom, $urandom};
        serve("re_en", 1'b1, 8'h3b, 8'h00, 4'd6, 1'b0, rx, 0);
        check_read_ok("re_en", rx);

        // reset while a read is outstanding
        wait_req("rst_rd");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ctrl", {drv_tick, drv_run_req, drv_r_en, drv_reg_addr, drv_send_data,
                           drv_num_data, rd_valid, init_done, fault, busy}, 27'd0);
        check("rst_rd_data", rd_data, 48'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // init restarts at entry 0; every attempt NACKed -> 1 + MAX_RETRY tries
        for (int a = 0; a < 4; a++) begin
            check("pre_fault", fault, 1'b0);
            serve("nack_all", 1'b0, exp_init_addr[0], exp_init_data[0], 4'd1, 1'b1, '0, 0);
        end
        check("fault_set", fault, 1'b1);
        check("fault_no_init", init_done, 1'b0);
        lows = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (drv_run_req !== 1'b0) lows++;
        end
        check("fault_no_req", 64'(lows), 64'd0);
        check("fault_sticky", fault, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
